// File: rtl/enigma_pkg.sv
// Shared Enigma constants: alphabet size, rotor wiring ROMs (forward and inverse),
// notch positions and the mod-26 helpers used by every rotor stage.
package enigma_pkg;

    localparam int ALPHA = 26;
    localparam int LW    = 5;
    localparam int NUM_ROTORS = 5;

    // Wiring tables as letter strings (first character = entry A) for readability.
    localparam logic [8*ALPHA-1:0] W_STR [NUM_ROTORS] = '{
        "EKMFLGDQVZNTOWYHXUSPAIBRCJ",
        "AJDKSIRUXBLHWTMCQGZNPYFVOE",
        "BDFHJLCPRTXVZNYEIWGAKMUSQO",
        "ESOVPZJAYQUIRHXLNFTGKDCMWB",
        "VZBRGITYUPSDNHLXAWMJQOFECK"
    };

    localparam logic [8*ALPHA-1:0] WINV_STR [NUM_ROTORS] = '{
        "UWYGADFPVZBECKMTHXSLRINQOJ",
        "AJPCZWRLFBDKOTYUQGENHXMIVS",
        "TAGBPCSDQEUFVNZHYIXJWLRKOM",
        "HZWVARTNLGUPXQCEJMBSKDYOIF",
        "QCYLXWENFTZOSMVJUDKGIARPHB"
    };

    localparam logic [LW-1:0] NOTCH [NUM_ROTORS] = '{5'd16, 5'd4, 5'd21, 5'd9, 5'd25};

    function automatic logic [LW-1:0] rom_letter(input logic [8*ALPHA-1:0] s,
                                                 input logic [LW-1:0] idx);
        logic [7:0] c;
        if (idx >= LW'(ALPHA))
            return '0;
        c = s[8*(ALPHA-1-int'(idx)) +: 8];
        return LW'(c - 8'h41);
    endfunction

    function automatic logic [LW-1:0] w_lookup(input int sel, input logic [LW-1:0] idx);
        return rom_letter(W_STR[sel], idx);
    endfunction

    function automatic logic [LW-1:0] winv_lookup(input int sel, input logic [LW-1:0] idx);
        return rom_letter(WINV_STR[sel], idx);
    endfunction

    function automatic logic [LW-1:0] mod26_add(input logic [LW-1:0] a, input logic [LW-1:0] b);
        logic [LW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (LW+1)'(ALPHA))
            s = s - (LW+1)'(ALPHA);
        return s[LW-1:0];
    endfunction

    function automatic logic [LW-1:0] mod26_sub(input logic [LW-1:0] a, input logic [LW-1:0] b);
        logic [LW:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (a < b)
            d = d + (LW+1)'(ALPHA);
        return d[LW-1:0];
    endfunction

    function automatic logic [LW-1:0] mod26_reduce(input logic [LW-1:0] v);
        return (v >= LW'(ALPHA)) ? LW'(v - LW'(ALPHA)) : v;
    endfunction

endpackage

// File: rtl/enigma_rotor_map.sv
// Combinational rotor substitution: shifts the letter by the rotor offset k, looks it up in
// the forward or inverse wiring, and shifts back.
module enigma_rotor_map
    import enigma_pkg::*;
#(
    parameter int WIRING_SEL = 0
) (
    input  logic [LW-1:0] x,
    input  logic [LW-1:0] k,
    input  logic          dir,
    output logic [LW-1:0] y
);

    logic [LW-1:0] idx;
    logic [LW-1:0] wired;

    always_comb begin
        idx   = mod26_add(x, k);
        wired = dir ? winv_lookup(WIRING_SEL, idx) : w_lookup(WIRING_SEL, idx);
        y     = mod26_sub(wired, k);
    end

endmodule

// File: rtl/enigma_rotor_stage.sv
// Stepping Enigma rotor with valid/ready handshake and one-cycle latency.
// Optional historical double-step of the middle rotor: define ENIGMA_DOUBLE_STEP_EN.
module enigma_rotor_stage
    import enigma_pkg::*;
#(
    parameter int WIRING_SEL  = 0,
    parameter bit STEP_ALWAYS = 1'b0,
    parameter bit IS_MIDDLE   = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_load,
    input  logic [LW-1:0] cfg_pos,
    input  logic [LW-1:0] cfg_ring,
    input  logic          dir,
    input  logic          step_in,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [LW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [LW-1:0] out_data,
    output logic          out_err,
    output logic          step_out,
    output logic [LW-1:0] pos
);

`ifdef ENIGMA_DOUBLE_STEP_EN
    localparam bit DOUBLE_STEP_EN = 1'b1;
`else
    localparam bit DOUBLE_STEP_EN = 1'b0;
`endif

    logic [LW-1:0] ring;
    logic [LW-1:0] pos_n;
    logic [LW-1:0] k;
    logic [LW-1:0] map_out;
    logic          accept;
    logic          in_range;
    logic          at_notch;
    logic          stepping;

    // Stepping happens before encoding, so the offset is derived from the next position.
    always_comb begin
        in_ready = !cfg_load && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
        in_range = in_data < LW'(ALPHA);
        at_notch = pos == NOTCH[WIRING_SEL];
        stepping = accept && in_range &&
                   (STEP_ALWAYS || step_in || (DOUBLE_STEP_EN && IS_MIDDLE && at_notch));
        step_out = stepping && at_notch;
        if (stepping)
            pos_n = (pos == LW'(ALPHA - 1)) ? '0 : pos + 1'b1;
        else
            pos_n = pos;
        k = mod26_sub(pos_n, ring);
    end

    enigma_rotor_map #(
        .WIRING_SEL(WIRING_SEL)
    ) u_map (
        .x  (in_data),
        .k  (k),
        .dir(dir),
        .y  (map_out)
    );

    // Configuration load blocks acceptance, so position update and letter capture never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos       <= '0;
            ring      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else begin
            if (cfg_load) begin
                pos  <= mod26_reduce(cfg_pos);
                ring <= mod26_reduce(cfg_ring);
            end else if (accept) begin
                pos <= pos_n;
            end
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= in_range ? map_out : in_data;
                out_err   <= !in_range;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_enigma_rotor_stage.sv
// Directed bench for enigma_rotor_stage: rotor I (always-step and carry-step) and rotor II middle.
// Expected double-step behaviour follows ENIGMA_DOUBLE_STEP_EN.
module tb_enigma_rotor_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_load;
    logic [4:0] cfg_pos;
    logic [4:0] cfg_ring;
    logic       dir;
    logic       step_in;
    logic       in_valid;
    logic [4:0] in_data;
    logic       out_ready;

    logic       a_in_ready, a_out_valid, a_out_err, a_step_out;
    logic [4:0] a_out_data, a_pos;
    logic       b_in_ready, b_out_valid, b_out_err, b_step_out;
    logic [4:0] b_out_data, b_pos;
    logic       c_in_ready, c_out_valid, c_out_err, c_step_out;
    logic [4:0] c_out_data, c_pos;

    int testCount = 0;
    int failCount = 0;

`ifdef ENIGMA_DOUBLE_STEP_EN
    localparam logic [7:0] DS_STEP = 8'd1;
    localparam logic [7:0] DS_POS  = 8'd5;
    localparam logic [7:0] DS_OUT  = 8'd3;
`else
    localparam logic [7:0] DS_STEP = 8'd0;
    localparam logic [7:0] DS_POS  = 8'd4;
    localparam logic [7:0] DS_OUT  = 8'd14;
`endif

    always #5 clk = ~clk;

    enigma_rotor_stage #(.WIRING_SEL(0), .STEP_ALWAYS(1'b1), .IS_MIDDLE(1'b0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pos(cfg_pos), .cfg_ring(cfg_ring),
        .dir(dir), .step_in(step_in), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_err(a_out_err), .step_out(a_step_out), .pos(a_pos)
    );

    enigma_rotor_stage #(.WIRING_SEL(0), .STEP_ALWAYS(1'b0), .IS_MIDDLE(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pos(cfg_pos), .cfg_ring(cfg_ring),
        .dir(dir), .step_in(step_in), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_err(b_out_err), .step_out(b_step_out), .pos(b_pos)
    );

    enigma_rotor_stage #(.WIRING_SEL(1), .STEP_ALWAYS(1'b0), .IS_MIDDLE(1'b1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pos(cfg_pos), .cfg_ring(cfg_ring),
        .dir(dir), .step_in(step_in), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_data(c_out_data), .out_err(c_out_err), .step_out(c_step_out), .pos(c_pos)
    );

    // Drives all shared inputs; called right after a falling edge.
    task automatic applyStimulus(input bit ld, input logic [4:0] p, input logic [4:0] r,
                                 input bit d, input bit s, input bit v,
                                 input logic [4:0] data, input bit rdy);
        cfg_load  = ld;
        cfg_pos   = p;
        cfg_ring  = r;
        dir       = d;
        step_in   = s;
        in_valid  = v;
        in_data   = data;
        out_ready = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_pos", 8'(a_pos), 8'd0);
        checkOutput("reset_out_valid", 8'(a_out_valid), 8'd0);
        checkOutput("reset_out_data", 8'(a_out_data), 8'd0);
        checkOutput("reset_out_err", 8'(a_out_err), 8'd0);
        checkOutput("reset_step_out", 8'(a_step_out), 8'd0);
        checkOutput("reset_in_ready", 8'(a_in_ready), 8'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Load A/A while a letter is offered: nothing accepted
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 1);
        #1 checkOutput("load_blocks_ready", 8'(a_in_ready), 8'd0);
        tick();
        checkOutput("load_no_output", 8'(a_out_valid), 8'd0);

        // Rotor I always-step, A in -> J, position B
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);
        #1 checkOutput("t1_step_out", 8'(a_step_out), 8'd0);
        tick();
        checkOutput("t1_pos", 8'(a_pos), 8'd1);
        checkOutput("t1_out_valid", 8'(a_out_valid), 8'd1);
        checkOutput("t1_out_data", 8'(a_out_data), 8'd9);
        checkOutput("t1_nostep_pos", 8'(b_pos), 8'd0);
        checkOutput("t1_nostep_data", 8'(b_out_data), 8'd4);
        checkOutput("t1_rotor2_data", 8'(c_out_data), 8'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        checkOutput("drain_valid", 8'(a_out_valid), 8'd0);

        // Notch carry at Q
        applyStimulus(1, 16, 0, 0, 0, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 1);
        #1 checkOutput("t2_step_out", 8'(b_step_out), 8'd1);
        tick();
        checkOutput("t2_pos", 8'(b_pos), 8'd17);
        checkOutput("t2_out_data", 8'(b_out_data), 8'd3);

        // Wrap Z -> A without carry
        applyStimulus(1, 25, 0, 0, 0, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 1);
        #1 checkOutput("t3_step_out", 8'(b_step_out), 8'd0);
        tick();
        checkOutput("t3_pos", 8'(b_pos), 8'd0);
        checkOutput("t3_out_data", 8'(b_out_data), 8'd4);

        // Reverse A -> U, then out-of-range letter back to back
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 1, 0, 1, 0, 1);
        tick();
        checkOutput("t4_rev_data", 8'(b_out_data), 8'd20);
        checkOutput("t4_rev_pos", 8'(b_pos), 8'd0);
        applyStimulus(0, 0, 0, 1, 0, 1, 27, 1);
        tick();
        checkOutput("t4_err", 8'(b_out_err), 8'd1);
        checkOutput("t4_err_data", 8'(b_out_data), 8'd27);
        checkOutput("t4_err_valid", 8'(b_out_valid), 8'd1);
        checkOutput("t4_err_pos", 8'(b_pos), 8'd0);
        checkOutput("t4_err_nostep_always", 8'(a_pos), 8'd1);

        // Backpressure holds output
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        #1 checkOutput("t5_stall_ready", 8'(b_in_ready), 8'd0);
        tick();
        checkOutput("t5_hold_data", 8'(b_out_data), 8'd27);
        checkOutput("t5_hold_err", 8'(b_out_err), 8'd1);
        checkOutput("t5_hold_valid", 8'(b_out_valid), 8'd1);

        // Load during offered letter: load wins, output drains
        applyStimulus(1, 5, 3, 0, 0, 1, 0, 1);
        #1 checkOutput("t5_load_ready", 8'(b_in_ready), 8'd0);
        tick();
        checkOutput("t5_load_pos", 8'(b_pos), 8'd5);
        checkOutput("t5_load_drain", 8'(b_out_valid), 8'd0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);
        tick();
        checkOutput("ring_out_data", 8'(b_out_data), 8'd10);
        checkOutput("ring_out_err", 8'(b_out_err), 8'd0);

        // Out-of-range config values reduced mod 26 (30->4, 29->3)
        applyStimulus(1, 30, 29, 0, 0, 0, 0, 1);
        tick();
        checkOutput("cfg_mod_pos", 8'(b_pos), 8'd4);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);
        tick();
        checkOutput("cfg_mod_ring_data", 8'(b_out_data), 8'd9);

        // Middle rotor II at its notch E with no incoming carry
        applyStimulus(1, 4, 0, 0, 0, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);
        #1 checkOutput("t6_step_out", 8'(c_step_out), DS_STEP);
        tick();
        checkOutput("t6_pos", 8'(c_pos), DS_POS);
        checkOutput("t6_out_data", 8'(c_out_data), DS_OUT);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
